// File: rtl/collision_engine_if.sv
// Bus between the game-state FSM and the collision engine.
// Master issues evaluate/clear and snapshots; slave returns crash state.
interface collision_engine_if #(
  parameter int Y_WIDTH   = 7,
  parameter int X_WIDTH   = 8,
  parameter int NUM_PIPES = 4,
  parameter int IDX_WIDTH = 2
);
  logic                           evaluateCollision;
  logic                           clearCrash;
  logic [Y_WIDTH-1:0]             yBird;
  logic [NUM_PIPES-1:0]           pipeValid;
  logic [NUM_PIPES*X_WIDTH-1:0]   pipeX;
  logic [NUM_PIPES*Y_WIDTH-1:0]   gapTop;
  logic                           busy;
  logic                           done;
  logic                           crashHappen;
  logic [1:0]                     crashCause;
  logic [IDX_WIDTH-1:0]           crashPipe;

  modport master (
    output evaluateCollision,
    output clearCrash,
    output yBird,
    output pipeValid,
    output pipeX,
    output gapTop,
    input  busy,
    input  done,
    input  crashHappen,
    input  crashCause,
    input  crashPipe
  );

  modport slave (
    input  evaluateCollision,
    input  clearCrash,
    input  yBird,
    input  pipeValid,
    input  pipeX,
    input  gapTop,
    output busy,
    output done,
    output crashHappen,
    output crashCause,
    output crashPipe
  );
endinterface

// File: rtl/collision_engine.sv
// Bird collision engine: floor/ceiling check, then one pipe per cycle.
// Keeps a sticky crash flag with cause and pipe index until cleared.
module collision_engine #(
  parameter int Y_WIDTH   = 7,
  parameter int X_WIDTH   = 8,
  parameter int NUM_PIPES = 4,
  parameter int IDX_WIDTH = 2,
  parameter int FLOOR_Y   = 116,
  parameter int CEIL_EN   = 1,
  parameter int CEIL_Y    = 0,
  parameter int BIRD_X    = 20,
  parameter int BIRD_W    = 6,
  parameter int BIRD_H    = 6,
  parameter int PIPE_W    = 10,
  parameter int GAP_H     = 32
) (
  input logic clk,
  input logic resetHigh,
  collision_engine_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SURFACE,
    SCAN,
    DONE
  } state_t;

  localparam int YE = Y_WIDTH + 1;
  localparam int XE = X_WIDTH + 1;

  localparam logic [YE-1:0] FY = YE'(FLOOR_Y);
  localparam logic [YE-1:0] CY = YE'(CEIL_Y);
  localparam logic [YE-1:0] BH = YE'(BIRD_H);
  localparam logic [YE-1:0] GH = YE'(GAP_H);
  localparam logic [XE-1:0] BL = XE'(BIRD_X);
  localparam logic [XE-1:0] BR = XE'(BIRD_X + BIRD_W);
  localparam logic [XE-1:0] PW = XE'(PIPE_W);

  localparam logic CEIL_ON = (CEIL_EN != 0);

  localparam logic [IDX_WIDTH-1:0] LAST =
    IDX_WIDTH'(NUM_PIPES - 1);

  localparam logic [1:0] C_FLOOR = 2'd1;
  localparam logic [1:0] C_CEIL  = 2'd2;
  localparam logic [1:0] C_PIPE  = 2'd3;

  state_t state_q, state_d;

  logic [Y_WIDTH-1:0]   y_q, y_d;
  logic [NUM_PIPES-1:0] vld_q, vld_d;
  logic [X_WIDTH-1:0]   px_q [NUM_PIPES];
  logic [X_WIDTH-1:0]   px_d [NUM_PIPES];
  logic [Y_WIDTH-1:0]   gt_q [NUM_PIPES];
  logic [Y_WIDTH-1:0]   gt_d [NUM_PIPES];
  logic [IDX_WIDTH-1:0] idx_q, idx_d;

  logic                 crash_q, crash_d;
  logic [1:0]           cause_q, cause_d;
  logic [IDX_WIDTH-1:0] cpipe_q, cpipe_d;

  logic [YE-1:0] y_e;
  logic [YE-1:0] gt_e;
  logic [XE-1:0] px_e;
  logic          floor_hit;
  logic          ceil_hit;
  logic          x_ovl;
  logic          y_out;
  logic          pipe_hit;

  // Hit tests on the snapshot; sums widened so nothing wraps
  always_comb begin
    y_e       = {1'b0, y_q};
    gt_e      = {1'b0, gt_q[idx_q]};
    px_e      = {1'b0, px_q[idx_q]};
    floor_hit = (y_e >= FY);
    ceil_hit  = CEIL_ON && (y_e <= CY);
    x_ovl     = (px_e < BR) && ((px_e + PW) > BL);
    y_out     = (y_e < gt_e) || ((y_e + BH) > (gt_e + GH));
    pipe_hit  = vld_q[idx_q] && x_ovl && y_out;
  end

  // Next-state, snapshot capture and sticky crash update
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    vld_d   = vld_q;
    px_d    = px_q;
    gt_d    = gt_q;
    idx_d   = idx_q;
    crash_d = crash_q;
    cause_d = cause_q;
    cpipe_d = cpipe_q;
    unique case (state_q)
      IDLE: begin
        if (bus.clearCrash) begin
          crash_d = 1'b0;
          cause_d = 2'd0;
          cpipe_d = '0;
        end
        if (bus.evaluateCollision) begin
          y_d   = bus.yBird;
          vld_d = bus.pipeValid;
          for (int i = 0; i < NUM_PIPES; i++) begin
            px_d[i] = bus.pipeX[i*X_WIDTH +: X_WIDTH];
            gt_d[i] = bus.gapTop[i*Y_WIDTH +: Y_WIDTH];
          end
          state_d = SURFACE;
        end
      end
      SURFACE: begin
        if (floor_hit) begin
          state_d = DONE;
          if (!crash_q) begin
            crash_d = 1'b1;
            cause_d = C_FLOOR;
            cpipe_d = '0;
          end
        end else if (ceil_hit) begin
          state_d = DONE;
          if (!crash_q) begin
            crash_d = 1'b1;
            cause_d = C_CEIL;
            cpipe_d = '0;
          end
        end else begin
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (pipe_hit) begin
          state_d = DONE;
          if (!crash_q) begin
            crash_d = 1'b1;
            cause_d = C_PIPE;
            cpipe_d = idx_q;
          end
        end else if (idx_q == LAST) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, snapshot and crash registers
  always_ff @(posedge clk or posedge resetHigh) begin
    if (resetHigh) begin
      state_q <= IDLE;
      y_q     <= '0;
      vld_q   <= '0;
      idx_q   <= '0;
      crash_q <= 1'b0;
      cause_q <= 2'd0;
      cpipe_q <= '0;
      for (int i = 0; i < NUM_PIPES; i++) begin
        px_q[i] <= '0;
        gt_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      vld_q   <= vld_d;
      idx_q   <= idx_d;
      crash_q <= crash_d;
      cause_q <= cause_d;
      cpipe_q <= cpipe_d;
      px_q    <= px_d;
      gt_q    <= gt_d;
    end
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = (state_q == DONE);
  assign bus.crashHappen = crash_q;
  assign bus.crashCause  = cause_q;
  assign bus.crashPipe   = cpipe_q;

endmodule

// File: tb/tb_collision_engine.sv
// Bench for collision_engine: directed cases then random evaluations
// checked against a plain-arithmetic reference model.
module tb_collision_engine;

  localparam int YW      = 7;
  localparam int XW      = 8;
  localparam int NP      = 4;
  localparam int IW      = 2;
  localparam int FLOOR_Y = 116;
  localparam int CEIL_EN = 1;
  localparam int CEIL_Y  = 0;
  localparam int BIRD_X  = 20;
  localparam int BIRD_W  = 6;
  localparam int BIRD_H  = 6;
  localparam int PIPE_W  = 10;
  localparam int GAP_H   = 32;

  logic clk = 1'b0;
  logic resetHigh;

  always #5 clk = ~clk;

  collision_engine_if #(
    .Y_WIDTH(YW), .X_WIDTH(XW),
    .NUM_PIPES(NP), .IDX_WIDTH(IW)
  ) bus ();

  collision_engine #(
    .Y_WIDTH(YW), .X_WIDTH(XW),
    .NUM_PIPES(NP), .IDX_WIDTH(IW),
    .FLOOR_Y(FLOOR_Y), .CEIL_EN(CEIL_EN),
    .CEIL_Y(CEIL_Y), .BIRD_X(BIRD_X),
    .BIRD_W(BIRD_W), .BIRD_H(BIRD_H),
    .PIPE_W(PIPE_W), .GAP_H(GAP_H)
  ) dut (
    .clk(clk),
    .resetHigh(resetHigh),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  int tpx [NP];
  int tgt [NP];

  int m_crash = 0;
  int m_cause = 0;
  int m_pipe  = 0;

  task automatic chk(input string tag,
                     input int obs,
                     input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d",
               tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void ref_eval(
    input  int             y,
    input  logic [NP-1:0]  v,
    output int             cause,
    output int             pipe,
    output int             lat
  );
    cause = 0;
    pipe  = 0;
    lat   = 2 + NP;
    if (y >= FLOOR_Y) begin
      cause = 1;
      lat   = 2;
      return;
    end
    if (CEIL_EN != 0 && y <= CEIL_Y) begin
      cause = 2;
      lat   = 2;
      return;
    end
    for (int i = 0; i < NP; i++) begin
      if (v[i]
          && tpx[i] < BIRD_X + BIRD_W
          && tpx[i] + PIPE_W > BIRD_X
          && (y < tgt[i]
              || y + BIRD_H > tgt[i] + GAP_H)) begin
        cause = 3;
        pipe  = i;
        lat   = 3 + i;
        return;
      end
    end
  endfunction

  task automatic check_fields(input string pfx);
    chk({pfx, "_crash"}, int'(bus.crashHappen), m_crash);
    chk({pfx, "_cause"}, int'(bus.crashCause), m_cause);
    chk({pfx, "_pipe"}, int'(bus.crashPipe), m_pipe);
  endtask

  task automatic run_eval(input int            y,
                          input logic [NP-1:0] v,
                          input bit            clr,
                          input bit            scr);
    int c, p, lat, n;
    bus.yBird     = YW'(y);
    bus.pipeValid = v;
    for (int i = 0; i < NP; i++) begin
      bus.pipeX[i*XW +: XW]  = XW'(tpx[i]);
      bus.gapTop[i*YW +: YW] = YW'(tgt[i]);
    end
    bus.evaluateCollision = 1'b1;
    bus.clearCrash        = clr;
    if (clr) begin
      m_crash = 0;
      m_cause = 0;
      m_pipe  = 0;
    end
    ref_eval(y, v, c, p, lat);
    if (m_crash == 0 && c != 0) begin
      m_crash = 1;
      m_cause = c;
      m_pipe  = p;
    end
    step();
    bus.evaluateCollision = 1'b0;
    bus.clearCrash        = 1'b0;
    n = 1;
    chk("busy_start", int'(bus.busy), 1);
    while (!bus.done && n < 40) begin
      if (scr) begin
        bus.yBird     = YW'($urandom);
        bus.pipeValid = NP'($urandom);
        bus.pipeX     = (NP*XW)'($urandom);
        bus.gapTop    = (NP*YW)'($urandom);
        bus.evaluateCollision = 1'($urandom_range(0, 1));
        bus.clearCrash        = 1'($urandom_range(0, 1));
      end
      step();
      n++;
    end
    bus.evaluateCollision = 1'b0;
    bus.clearCrash        = 1'b0;
    chk("latency", n, lat);
    check_fields("done");
    step();
    chk("idle_done", int'(bus.done), 0);
    chk("idle_busy", int'(bus.busy), 0);
  endtask

  task automatic do_clear();
    bus.clearCrash = 1'b1;
    step();
    bus.clearCrash = 1'b0;
    m_crash = 0;
    m_cause = 0;
    m_pipe  = 0;
    check_fields("clear");
  endtask

  initial begin
    resetHigh             = 1'b1;
    bus.evaluateCollision = 1'b0;
    bus.clearCrash        = 1'b0;
    bus.yBird             = '0;
    bus.pipeValid         = '0;
    bus.pipeX             = '0;
    bus.gapTop            = '0;
    for (int i = 0; i < NP; i++) begin
      tpx[i] = 200;
      tgt[i] = 40;
    end
    step();
    step();
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    check_fields("rst");
    resetHigh = 1'b0;
    step();

    // floor at the boundary and just above it
    run_eval(116, 4'b0000, 1'b0, 1'b0);
    run_eval(115, 4'b0000, 1'b1, 1'b0);

    // ceiling
    run_eval(0, 4'b0000, 1'b1, 1'b0);

    // pipe scan: channel 1 misses, channel 3 hits
    tpx[1] = 18; tgt[1] = 40;
    tpx[3] = 20; tgt[3] = 10;
    run_eval(60, 4'b1010, 1'b1, 1'b0);
    // early exit on channel 1
    run_eval(38, 4'b1010, 1'b1, 1'b0);

    // sticky: floor crash survives a later pipe hit
    run_eval(116, 4'b1010, 1'b1, 1'b0);
    run_eval(60, 4'b1010, 1'b0, 1'b0);
    do_clear();
    run_eval(116, 4'b0000, 1'b1, 1'b0);

    // inputs and requests churn mid-evaluation
    run_eval(60, 4'b1010, 1'b1, 1'b1);
    run_eval(38, 4'b1010, 1'b1, 1'b1);

    // reset during SCAN clears everything at once
    run_eval(116, 4'b0000, 1'b0, 1'b0);
    bus.yBird             = YW'(60);
    bus.pipeValid         = '0;
    bus.evaluateCollision = 1'b1;
    step();
    bus.evaluateCollision = 1'b0;
    step();
    step();
    resetHigh = 1'b1;
    #1;
    chk("mid_rst_busy", int'(bus.busy), 0);
    chk("mid_rst_done", int'(bus.done), 0);
    m_crash = 0;
    m_cause = 0;
    m_pipe  = 0;
    check_fields("mid_rst");
    for (int k = 0; k < 3; k++) begin
      step();
      chk("mid_rst_nodone", int'(bus.done), 0);
    end
    resetHigh = 1'b0;
    step();
    run_eval(60, 4'b1010, 1'b0, 1'b0);

    // random evaluations
    for (int t = 0; t < 150; t++) begin
      int            y;
      logic [NP-1:0] v;
      bit            clr;
      bit            scr;
      y = $urandom_range(0, 127);
      v = NP'($urandom);
      for (int i = 0; i < NP; i++) begin
        if ($urandom_range(0, 1) == 1)
          tpx[i] = $urandom_range(5, 35);
        else
          tpx[i] = $urandom_range(0, 255);
        tgt[i] = $urandom_range(0, 127);
      end
      clr = ($urandom_range(0, 3) == 0);
      scr = 1'($urandom_range(0, 1));
      run_eval(y, v, clr, scr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
